wb_regfile: RTL and testbench

- Consumer end of the MEM/WB pipeline register: the write-back stage plus the 32x32 MIPS general-purpose register file.
- Takes the registered MEM/WB control and data, selects the write-back value and commits it to the register file.
- Serves the ID-stage read ports with same-cycle write bypass.
- Exports the committed write (data, address, enable) to the EX forwarding unit, and counts retired register writes for debug.

---
 rtl/wb_regfile.sv | 104 ++++++++++
 tb/tb_wb_regfile.sv | 332 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/wb_regfile.sv
// Write-back stage and 32x32 MIPS general-purpose register file.
// Selects the write-back value from the MEM/WB register, commits it to the
// array, serves three combinational read ports with write-first bypass, and
// exports the committed write to the EX forwarding unit.
module wb_regfile #(
    parameter logic [31:0] SP_INIT  = 32'h0000_2FFC,
    parameter logic [31:0] GP_INIT  = 32'h0000_1800,
    parameter logic [31:0] LINK_OFS = 32'd4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        RegWrite,
    input  logic [1:0]  WDSel,
    input  logic [31:0] aluout,
    input  logic [31:0] readdata,
    input  logic [4:0]  A3,
    input  logic [31:0] PC,
    input  logic [4:0]  A1,
    input  logic [4:0]  A2,
    output logic [31:0] RD1,
    output logic [31:0] RD2,
    output logic [31:0] WBdata,
    output logic [4:0]  WBaddr,
    output logic        WBen,
    input  logic [4:0]  dbgA,
    output logic [31:0] dbgD,
    output logic [31:0] wcount
);

    logic [31:0] regs_q [32];
    logic [31:0] wcount_q;
    logic [31:0] wcount_d;

    // Write-data select and effective write qualification ($0 is never written).
    always_comb begin
        WBdata = aluout;
        unique case (WDSel)
            2'b00:   WBdata = aluout;
            2'b01:   WBdata = readdata;
            2'b10:   WBdata = PC + LINK_OFS;
            default: WBdata = aluout;
        endcase
        WBaddr = A3;
        WBen   = RegWrite && (A3 != 5'd0);
    end

    // Read with write-first bypass; $0 reads zero even when bypass would hit.
    function automatic logic [31:0] read_port(
        input logic [4:0]  addr,
        input logic [31:0] arr_val,
        input logic        wen,
        input logic [4:0]  waddr,
        input logic [31:0] wdata
    );
        logic [31:0] val;
        val = arr_val;
        if (wen && (addr == waddr)) begin
            val = wdata;
        end
        if (addr == 5'd0) begin
            val = '0;
        end
        return val;
    endfunction

    // Three independent read ports, each bypassing the current write.
    always_comb begin
        RD1  = read_port(A1,   regs_q[A1],   WBen, A3, WBdata);
        RD2  = read_port(A2,   regs_q[A2],   WBen, A3, WBdata);
        dbgD = read_port(dbgA, regs_q[dbgA], WBen, A3, WBdata);
    end

    // Register array: reset to zero except $gp/$sp, commit one write per edge.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int unsigned i = 0; i < 32; i++) begin
                regs_q[i[4:0]] <= (i == 28) ? GP_INIT :
                                  (i == 29) ? SP_INIT : '0;
            end
        end else if (WBen) begin
            regs_q[A3] <= WBdata;
        end
    end

    // Retired-write counter next state; wraps naturally at 2^32.
    always_comb begin
        wcount_d = wcount_q;
        if (WBen) begin
            wcount_d = wcount_q + 32'd1;
        end
    end

    // Retired-write counter register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wcount_q <= '0;
        end else begin
            wcount_q <= wcount_d;
        end
    end

    assign wcount = wcount_q;

endmodule

// File: tb/tb_wb_regfile.sv
// Self-checking bench for wb_regfile: directed scenarios plus a randomized
// run against an array-based reference model of the register file.
module tb_wb_regfile;

    logic        clk = 1'b0;
    logic        rst;
    logic        RegWrite;
    logic [1:0]  WDSel;
    logic [31:0] aluout;
    logic [31:0] readdata;
    logic [4:0]  A3;
    logic [31:0] PC;
    logic [4:0]  A1;
    logic [4:0]  A2;
    logic [31:0] RD1;
    logic [31:0] RD2;
    logic [31:0] WBdata;
    logic [4:0]  WBaddr;
    logic        WBen;
    logic [4:0]  dbgA;
    logic [31:0] dbgD;
    logic [31:0] wcount;

    int unsigned total = 0;
    int unsigned bad   = 0;

    // Reference model state
    logic [31:0] mdl_regs [32];
    logic [31:0] mdl_cnt;

    wb_regfile #(
        .SP_INIT (32'h0000_2FFC),
        .GP_INIT (32'h0000_1800),
        .LINK_OFS(32'd4)
    ) dut (
        .clk     (clk),
        .rst     (rst),
        .RegWrite(RegWrite),
        .WDSel   (WDSel),
        .aluout  (aluout),
        .readdata(readdata),
        .A3      (A3),
        .PC      (PC),
        .A1      (A1),
        .A2      (A2),
        .RD1     (RD1),
        .RD2     (RD2),
        .WBdata  (WBdata),
        .WBaddr  (WBaddr),
        .WBen    (WBen),
        .dbgA    (dbgA),
        .dbgD    (dbgD),
        .wcount  (wcount)
    );

    always #5 clk = ~clk;

    function automatic void model_reset();
        for (int i = 0; i < 32; i++) mdl_regs[i] = 32'd0;
        mdl_regs[28] = 32'h0000_1800;
        mdl_regs[29] = 32'h0000_2FFC;
        mdl_cnt = 32'd0;
    endfunction

    function automatic logic [31:0] model_wdata();
        case (WDSel)
            2'b01:   return readdata;
            2'b10:   return PC + 32'd4;
            default: return aluout;
        endcase
    endfunction

    function automatic logic model_wen();
        return RegWrite && (A3 != 5'd0);
    endfunction

    function automatic logic [31:0] model_read(input logic [4:0] a);
        if (a == 5'd0) return 32'd0;
        if (model_wen() && a == A3) return model_wdata();
        return mdl_regs[a];
    endfunction

    // One clock edge; model commits what the inputs held at the edge.
    task automatic tick();
        logic        we;
        logic [31:0] wd;
        logic [4:0]  wa;
        we = model_wen();
        wd = model_wdata();
        wa = A3;
        @(posedge clk);
        if (we && rst) begin
            mdl_regs[wa] = wd;
            mdl_cnt = mdl_cnt + 32'd1;
        end
        @(negedge clk);
    endtask

    task automatic idle_inputs();
        RegWrite = 1'b0; WDSel = 2'b00; aluout = '0; readdata = '0;
        A3 = '0; PC = '0; A1 = '0; A2 = '0; dbgA = '0;
    endtask

    task automatic write_reg(input logic [4:0] a, input logic [31:0] v);
        RegWrite = 1'b1; WDSel = 2'b00; A3 = a; aluout = v;
        tick();
        RegWrite = 1'b0;
    endtask

    task automatic test_reset();
        logic [4:0]  addrs [3];
        logic [31:0] exps  [3];
        addrs[0] = 5'd29; exps[0] = 32'h0000_2FFC;
        addrs[1] = 5'd28; exps[1] = 32'h0000_1800;
        addrs[2] = 5'd5;  exps[2] = 32'h0000_0000;
        write_reg(5'd29, 32'hAAAA_0001);
        write_reg(5'd5,  32'hAAAA_0002);
        #1 rst = 1'b0;
        model_reset();
        for (int i = 0; i < 3; i++) begin
            dbgA = addrs[i];
            #1;
            total++;
            if (dbgD !== exps[i]) begin
                bad++;
                $display("FAIL reset_dbg[%0d]: got %h want %h", addrs[i], dbgD, exps[i]);
            end
        end
        total++;
        if (wcount !== 32'd0) begin
            bad++;
            $display("FAIL reset_wcount: got %h want 0", wcount);
        end
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_write_select();
        logic [1:0]  sels [3];
        logic [4:0]  dsts [3];
        logic [31:0] exps [3];
        sels[0] = 2'b00; dsts[0] = 5'd8;  exps[0] = 32'h0000_1234;
        sels[1] = 2'b01; dsts[1] = 5'd8;  exps[1] = 32'hDEAD_BEEF;
        sels[2] = 2'b10; dsts[2] = 5'd31; exps[2] = 32'h0040_0014;
        for (int i = 0; i < 3; i++) begin
            logic [31:0] cnt0;
            cnt0 = mdl_cnt;
            RegWrite = 1'b1; WDSel = sels[i]; A3 = dsts[i];
            aluout = 32'h0000_1234; readdata = 32'hDEAD_BEEF; PC = 32'h0040_0010;
            A1 = dsts[i];
            #1;
            total++;
            if (RD1 !== exps[i] || WBdata !== exps[i] || WBen !== 1'b1 || WBaddr !== dsts[i]) begin
                bad++;
                $display("FAIL wsel%0d_bypass: RD1=%h WBdata=%h WBen=%b WBaddr=%0d want %h/1/%0d",
                         i, RD1, WBdata, WBen, WBaddr, exps[i], dsts[i]);
            end
            tick();
            RegWrite = 1'b0; aluout = 32'h5555_5555; readdata = 32'h6666_6666;
            #1;
            total++;
            if (RD1 !== exps[i] || wcount !== cnt0 + 32'd1) begin
                bad++;
                $display("FAIL wsel%0d_commit: RD1=%h wcount=%0d want %h/%0d",
                         i, RD1, wcount, exps[i], cnt0 + 32'd1);
            end
        end
    endtask

    task automatic test_zero_guard();
        logic [31:0] cnt0;
        cnt0 = mdl_cnt;
        RegWrite = 1'b1; WDSel = 2'b00; A3 = 5'd0; aluout = 32'hFFFF_FFFF; A1 = 5'd0;
        #1;
        total++;
        if (WBen !== 1'b0 || RD1 !== 32'd0) begin
            bad++;
            $display("FAIL zero_guard_comb: WBen=%b RD1=%h want 0/0", WBen, RD1);
        end
        tick();
        RegWrite = 1'b0;
        #1;
        total++;
        if (RD1 !== 32'd0 || wcount !== cnt0) begin
            bad++;
            $display("FAIL zero_guard_commit: RD1=%h wcount=%0d want 0/%0d", RD1, wcount, cnt0);
        end
    endtask

    task automatic test_triple_bypass();
        write_reg(5'd9, 32'd3);
        A1 = 5'd9; A2 = 5'd9; dbgA = 5'd9; A3 = 5'd9; WDSel = 2'b00; aluout = 32'd7;
        RegWrite = 1'b1;
        #1;
        total++;
        if (RD1 !== 32'd7 || RD2 !== 32'd7 || dbgD !== 32'd7) begin
            bad++;
            $display("FAIL triple_bypass_pre: %h %h %h want 7", RD1, RD2, dbgD);
        end
        tick();
        RegWrite = 1'b0; aluout = 32'd99;
        #1;
        total++;
        if (RD1 !== 32'd7 || RD2 !== 32'd7 || dbgD !== 32'd7) begin
            bad++;
            $display("FAIL triple_bypass_post: %h %h %h want 7", RD1, RD2, dbgD);
        end
        write_reg(5'd9, 32'd3);
        A3 = 5'd9; aluout = 32'd7; RegWrite = 1'b0;
        #1;
        total++;
        if (RD1 !== 32'd3 || RD2 !== 32'd3 || dbgD !== 32'd3) begin
            bad++;
            $display("FAIL triple_nowrite: %h %h %h want 3", RD1, RD2, dbgD);
        end
        tick();
    endtask

    task automatic test_back_to_back();
        logic [31:0] cnt0;
        cnt0 = mdl_cnt;
        A2 = 5'd10;
        for (int v = 1; v <= 3; v++) begin
            RegWrite = 1'b1; WDSel = 2'b00; A3 = 5'd10; aluout = 32'(v);
            #1;
            total++;
            if (RD2 !== 32'(v)) begin
                bad++;
                $display("FAIL b2b_bypass%0d: got %h want %h", v, RD2, 32'(v));
            end
            tick();
        end
        RegWrite = 1'b0;
        #1;
        total++;
        if (RD2 !== 32'd3 || wcount !== cnt0 + 32'd3) begin
            bad++;
            $display("FAIL b2b_final: RD2=%h wcount=%0d want 3/%0d", RD2, wcount, cnt0 + 32'd3);
        end
    endtask

    task automatic test_reset_mid_write();
        write_reg(5'd12, 32'h0BAD_F00D);
        RegWrite = 1'b1; WDSel = 2'b00; A3 = 5'd12; aluout = 32'hCAFE_0012;
        #2 rst = 1'b0;
        model_reset();
        @(posedge clk);
        @(negedge clk);
        RegWrite = 1'b0;
        rst = 1'b1;
        dbgA = 5'd12;
        #1;
        total++;
        if (dbgD !== 32'd0 || wcount !== 32'd0) begin
            bad++;
            $display("FAIL reset_mid_write: dbgD=%h wcount=%0d want 0/0", dbgD, wcount);
        end
        @(negedge clk);
    endtask

    task automatic test_wrap();
        force dut.wcount_q = 32'hFFFF_FFFF;
        #1 release dut.wcount_q;
        mdl_cnt = 32'hFFFF_FFFF;
        #1;
        total++;
        if (wcount !== 32'hFFFF_FFFF) begin
            bad++;
            $display("FAIL wrap_preload: got %h want ffffffff", wcount);
        end
        write_reg(5'd3, 32'h1);
        #1;
        total++;
        if (wcount !== 32'd0) begin
            bad++;
            $display("FAIL wrap: got %h want 0", wcount);
        end
    endtask

    task automatic test_random();
        for (int n = 0; n < 300; n++) begin
            RegWrite = ($urandom_range(3) != 0);
            WDSel    = 2'($urandom_range(3));
            aluout   = $urandom;
            readdata = $urandom;
            PC       = $urandom;
            A3       = 5'($urandom_range(31));
            if ($urandom_range(3) == 0) A3 = 5'($urandom_range(3));
            A1   = ($urandom_range(2) == 0) ? A3 : 5'($urandom_range(31));
            A2   = ($urandom_range(2) == 0) ? A3 : 5'($urandom_range(31));
            dbgA = ($urandom_range(2) == 0) ? A3 : 5'($urandom_range(31));
            #1;
            total++;
            if (RD1 !== model_read(A1) || RD2 !== model_read(A2) || dbgD !== model_read(dbgA) ||
                WBdata !== model_wdata() || WBen !== model_wen() || WBaddr !== A3 ||
                wcount !== mdl_cnt) begin
                bad++;
                $display("FAIL random%0d: RD1=%h/%h RD2=%h/%h dbgD=%h/%h WBdata=%h/%h WBen=%b/%b wcount=%0d/%0d",
                         n, RD1, model_read(A1), RD2, model_read(A2), dbgD, model_read(dbgA),
                         WBdata, model_wdata(), WBen, model_wen(), wcount, mdl_cnt);
            end
            tick();
        end
    endtask

    initial begin
        idle_inputs();
        rst = 1'b0;
        model_reset();
        repeat (2) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        test_reset();
        test_write_select();
        test_zero_guard();
        test_triple_bypass();
        test_back_to_back();
        test_reset_mid_write();
        test_random();
        test_wrap();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation exceeded time limit");
        $fatal(1, "timeout");
    end

endmodule
